// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the RGB PWM driver
package led_pkg;

  localparam int unsigned DUTY_W_DEFAULT = 8;

  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  typedef struct packed {
    logic [DUTY_W_DEFAULT-1:0] r;
    logic [DUTY_W_DEFAULT-1:0] g;
    logic [DUTY_W_DEFAULT-1:0] b;
  } rgb_t;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// rtl/rgb_pwm_driver_if.sv - colour strobe bus from the colour-select mux
interface rgb_pwm_driver_if import led_pkg::*; ();

  rgb_t colour;
  logic colour_valid;

  modport master (output colour, output colour_valid);
  modport slave  (input  colour, input  colour_valid);

endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one colour channel: shadow duty, comparator, output flop
module pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned DUTY_W = DUTY_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic [DUTY_W-1:0] step,
  output logic              led
);

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              led_q, led_d;

  always_comb begin
    duty_d = duty_q;
    if (load) duty_d = duty_in;
    led_d = enable && (step < duty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - 24-bit colour to three glitch-free PWM LED drives
module rgb_pwm_driver
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned DUTY_W   = DUTY_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  rgb_pwm_driver_if.slave        cin,
  output logic                   led_r,
  output logic                   led_g,
  output logic                   led_b,
  output logic                   period_start
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic              live_q;
  logic [7:0]        presc_q, presc_d;
  logic [DUTY_W-1:0] step_q, step_d;
  logic              started_q, started_d;
  rgb_t              pending_q, pending_d;
  logic              pend_flag_q, pend_flag_d;
  logic              period_start_q;

  logic run, tick, boundary, load;
  rgb_t duty_src;

  // live_q holds the counters parked on the first edge after reset release
  always_comb begin
    run      = enable && live_q;
    tick     = run && (presc_q == PRE_LAST);
    boundary = tick && (!started_q || (step_q == '1));
    load     = boundary && (pend_flag_q || cin.colour_valid);
    duty_src = cin.colour_valid ? cin.colour : pending_q;

    presc_d = presc_q + 8'd1;
    if (!run || tick) presc_d = '0;

    step_d = step_q;
    if (!run || boundary) step_d = '0;
    else if (tick)        step_d = step_q + 1'b1;

    started_d   = run && (started_q || tick);
    pending_d   = cin.colour_valid ? cin.colour : pending_q;
    pend_flag_d = cin.colour_valid ? !boundary : (pend_flag_q && !boundary);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q         <= 1'b0;
      presc_q        <= '0;
      step_q         <= '0;
      started_q      <= 1'b0;
      pending_q      <= '0;
      pend_flag_q    <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      live_q         <= 1'b1;
      presc_q        <= presc_d;
      step_q         <= step_d;
      started_q      <= started_d;
      pending_q      <= pending_d;
      pend_flag_q    <= pend_flag_d;
      period_start_q <= boundary;
    end
  end

  assign period_start = period_start_q;

  pwm_channel #(.DUTY_W(DUTY_W)) u_ch_r (
    .clk(clk), .rst(rst), .enable(run), .load(load),
    .duty_in(duty_src[R_LSB +: DUTY_W]), .step(step_q), .led(led_r)
  );

  pwm_channel #(.DUTY_W(DUTY_W)) u_ch_g (
    .clk(clk), .rst(rst), .enable(run), .load(load),
    .duty_in(duty_src[G_LSB +: DUTY_W]), .step(step_q), .led(led_g)
  );

  pwm_channel #(.DUTY_W(DUTY_W)) u_ch_b (
    .clk(clk), .rst(rst), .enable(run), .load(load),
    .duty_in(duty_src[B_LSB +: DUTY_W]), .step(step_q), .led(led_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - directed self-checking bench for rgb_pwm_driver
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  logic rst;
  logic en1, en4;
  logic r1, g1, b1, ps1;
  logic r4, g4, b4, ps4;

  int n_assert = 0;
  int n_fail   = 0;

  int cr, cg, cb, nps, waited, hits;
  bit ps_end;

  always #5 clk = ~clk;

  rgb_pwm_driver_if bus1 ();
  rgb_pwm_driver_if bus4 ();

  rgb_pwm_driver #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .cin(bus1),
    .led_r(r1), .led_g(g1), .led_b(b1), .period_start(ps1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .cin(bus4),
    .led_r(r4), .led_g(g4), .led_b(b4), .period_start(ps4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_valid(input int sel, input logic v, input logic [23:0] col);
    if (sel == 0) begin
      bus1.colour_valid = v;
      if (v) bus1.colour = col;
    end else begin
      bus4.colour_valid = v;
      if (v) bus4.colour = col;
    end
  endtask

  function automatic logic [3:0] outs(input int sel);
    return (sel == 0) ? {ps1, r1, g1, b1} : {ps4, r4, g4, b4};
  endfunction

  task automatic wait_ps(input int sel, input int budget, output int w);
    w = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (outs(sel)[3]) begin
        w = i;
        break;
      end
    end
  endtask

  // Samples len cycles after a period_start; optionally strobes a colour at index inj_at
  task automatic measure(input int sel, input int len, input int inj_at, input logic [23:0] inj_col,
                         output int c_r, output int c_g, output int c_b, output int n_ps,
                         output bit last_ps);
    logic [3:0] o;
    c_r = 0; c_g = 0; c_b = 0; n_ps = 0; last_ps = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      drive_valid(sel, 1'b0, 24'h0);
      o = outs(sel);
      if (o[2]) c_r++;
      if (o[1]) c_g++;
      if (o[0]) c_b++;
      if (o[3]) begin
        n_ps++;
        last_ps = (i == len - 1);
      end
      if (i == inj_at) drive_valid(sel, 1'b1, inj_col);
    end
  endtask

  task automatic check_period(input string tag, input int er, input int eg, input int eb);
    check({tag, "_r"},   cr, er);
    check({tag, "_g"},   cg, eg);
    check({tag, "_b"},   cb, eb);
    check({tag, "_nps"}, nps, 1);
    check({tag, "_end"}, {31'd0, ps_end}, 1);
  endtask

  initial begin
    rst = 1'b1; en1 = 1'b0; en4 = 1'b0;
    bus1.colour = '0; bus1.colour_valid = 1'b0;
    bus4.colour = '0; bus4.colour_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs1", {28'd0, outs(0)}, 0);
    check("reset_outs4", {28'd0, outs(1)}, 0);
    rst = 1'b0;

    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (outs(0) != 4'd0) hits++;
    end
    check("idle_after_reset", hits, 0);

    // duty 80/00/FF
    drive_valid(0, 1'b1, 24'h80_00_FF);
    @(negedge clk);
    drive_valid(0, 1'b0, 24'h0);
    en1 = 1'b1;
    wait_ps(0, 10, waited);
    check("first_ps_latency", waited, 1);
    measure(0, 256, -1, 24'h0, cr, cg, cb, nps, ps_end);
    check_period("duty", 128, 0, 255);

    // colour change mid-period keeps old duty until the boundary
    measure(0, 256, 36, 24'h10_10_10, cr, cg, cb, nps, ps_end);
    check_period("glitch_old", 128, 0, 255);
    // strobe coincides with the boundary of this period
    measure(0, 256, 254, 24'h40_40_40, cr, cg, cb, nps, ps_end);
    check_period("glitch_new", 16, 16, 16);
    check("coinc_flag", {31'd0, dut1.pend_flag_q}, 0);
    measure(0, 256, -1, 24'h0, cr, cg, cb, nps, ps_end);
    check_period("coinc", 64, 64, 64);
    check("coinc_flag_after", {31'd0, dut1.pend_flag_q}, 0);

    // reset mid-period with led_r high and a colour pending
    @(negedge clk);
    check("pre_rst_led_r", {31'd0, r1}, 1);
    drive_valid(0, 1'b1, 24'hFF_FF_FF);
    @(negedge clk);
    drive_valid(0, 1'b0, 24'h0);
    check("pre_rst_led_r2", {31'd0, r1}, 1);
    #1 rst = 1'b1;
    en1 = 1'b0;
    #1 check("rst_async", {28'd0, outs(0)}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (outs(0) != 4'd0) hits++;
    end
    check("no_pulse_disabled", hits, 0);
    en1 = 1'b1;
    wait_ps(0, 10, waited);
    check("rst_first_ps", waited, 1);
    measure(0, 256, 100, 24'hC0_20_01, cr, cg, cb, nps, ps_end);
    check_period("pending_lost", 0, 0, 0);
    measure(0, 256, -1, 24'h0, cr, cg, cb, nps, ps_end);
    check_period("duty2", 192, 32, 1);

    // enable toggle
    repeat (20) @(negedge clk);
    check("pre_dis_led_r", {31'd0, r1}, 1);
    en1 = 1'b0;
    @(negedge clk);
    check("dis_outs", {28'd0, outs(0)}, 0);
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (outs(0) != 4'd0) hits++;
    end
    check("dis_quiet", hits, 0);
    en1 = 1'b1;
    wait_ps(0, 10, waited);
    check("reen_ps_latency", waited, 1);
    measure(0, 256, -1, 24'h0, cr, cg, cb, nps, ps_end);
    check_period("reen", 192, 32, 1);
    en1 = 1'b0;

    // PRESCALE=4 instance
    @(negedge clk);
    drive_valid(1, 1'b1, 24'h02_00_00);
    @(negedge clk);
    drive_valid(1, 1'b0, 24'h0);
    en4 = 1'b1;
    wait_ps(1, 20, waited);
    check("pre4_first_ps", waited, 4);
    measure(1, 1024, -1, 24'h0, cr, cg, cb, nps, ps_end);
    check_period("pre4", 8, 0, 0);
    en4 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
